l2_ctrl: RTL
============

# l2_ctrl

Sequencing controller for the 4-way, 32-set, 32-bit-line L2 array. Accepts one L1 request at a time (read miss or dirty-line writeback), performs tag lookup against the array's combinational read ports, and maintains per-way 2-bit LRU ages. It evicts dirty victims to main memory, fills from main memory and drives the array write strobes. It sits between the L1 controller and the L2 storage block.

## Interface
Clock `clk`; reset `rst`, synchronous, active-high. All other signals are sampled on the rising edge of `clk`.

Parameters:
- `TAG_W`, 25, tag width
- `IDX_W`, 5, set index width
- `WAYS`, 4, associativity (fixed; LRU encoding assumes 4)
- `LINE_W`, 32, line width

Ports:
- `clk` in 1 clock
- `rst` in 1 synchronous active-high reset
- `req_valid` in 1 L1 request present
- `req_ready` out 1 controller idle, can accept
- `req_write` in 1 1=L1 writeback of full line, 0=read
- `req_addr` in 32 {tag[31:7], index[6:2], offset[1:0]}
- `req_wdata` in 32 writeback line
- `resp_valid` out 1 one-cycle pulse: read data valid / write done
- `resp_data` out 32 line returned to L1
- `arr_index` out 5 set index to array
- `arr_tag` in 100 {tag3,tag2,tag1,tag0} of `arr_index`
- `arr_valid`, `arr_dirty` in 4 per-way state
- `arr_lru` in 8 {age3,...,age0}
- `arr_rdata` in 32 line of `arr_way` at `arr_index`
- `arr_way` out 2 way selected for read/write
- `arr_we` out 1 write line+tag+valid+dirty into `arr_way`
- `arr_wdata` out 32, `arr_wtag` out 25, `arr_wdirty` out 1
- `arr_lru_we` out 1, `arr_new_lru` out 8 LRU update
- `mem_req_valid` out 1, `mem_req_ready` in 1, `mem_we` out 1, `mem_addr` out 32 (offset bits 00), `mem_wdata` out 32
- `mem_resp_valid` in 1, `mem_rdata` in 32

## Operation
- FSM states: IDLE, LOOKUP, EVICT, FILL_REQ, FILL_WAIT, INSTALL, RESP.
- IDLE: `req_ready`=1. On `req_valid`, latch addr/write/wdata → LOOKUP.
- LOOKUP: hit = valid[w] && tag[w]==req tag; one hit at most (multiple hits are a protocol error, lowest way wins).
  - Read hit: `arr_way`=hit way, latch `arr_rdata`, LRU update → RESP.
  - Write hit: `arr_we`, dirty=1, LRU update → RESP.
  - Miss: victim = lowest invalid way, else the way with age 3. Dirty victim → EVICT; otherwise read → FILL_REQ and write → INSTALL.
- EVICT: `mem_we`=1, addr={victim tag, index, 00}, data=victim line. On `mem_req_ready` handshake, read → FILL_REQ and write → INSTALL.
- FILL_REQ: `mem_we`=0 read request. On handshake → FILL_WAIT.
- FILL_WAIT: on `mem_resp_valid`, latch `mem_rdata` → INSTALL. The pulse is ignored in every other state.
- INSTALL: `arr_we` into victim; dirty = `req_write`; data = fill or `req_wdata`; LRU update → RESP.
- RESP: `resp_valid`=1 (`resp_data` = line for reads, 0 for writes) → IDLE.
- LRU update: accessed way age→0; ways with age < the old accessed age increment by 1; others unchanged. An invalid victim counts as old age 3. Ages remain a permutation of 0..3.

## Timing
- Reset values: state IDLE, `req_ready`=1, and every other output 0. Reset mid-transaction aborts it: `mem_req_valid` drops the next cycle and no array write occurs.
- Hit latency: accept at cycle 0, LOOKUP at 1, RESP (`resp_valid`) at 2.
- Clean miss: 2 + memory handshake wait + response wait + INSTALL + RESP. A dirty miss adds the EVICT handshake.
- `mem_req_valid`, `mem_addr`, `mem_we` and `mem_wdata` stay stable until `mem_req_ready`.
- `arr_we` and `arr_lru_we` are single-cycle; the array commits them on that edge.
- `req_ready` is low in all non-IDLE states, with no back-to-back acceptance: IDLE lasts at least 1 cycle between requests.

## Structure
- Shared package `l2_pkg`: state enum; field widths (`TAG_W`, `IDX_W`, `OFF_W`=2); address slicing functions; LRU age width.
- One sub-module `l2_lru_update`, combinational: old ages plus accessed way in, new 8-bit ages out. It is reused by the L1 controller.

## Test plan
- Read hit: way2 tag 0x1, valid, ages {3,2,1,0}. Read addr 0x00000080 (tag 1, idx 0) gives `resp_valid` at cycle 2, data = way2 line, new ages {3,2,0,1}, no memory traffic.
- Clean read miss: idx 0 has way1 invalid. Read tag 5 gives `mem_addr`=0x00000280 read, memory returns 0xDEADBEEF, and the way1 install shows dirty 0, age 0, `resp_data`=0xDEADBEEF.
- Dirty eviction: all ways valid, way3 age 3 dirty with tag 7. Read miss gives a writeback to 0x00000380 with way3 data before the fill read; the fill lands in way3.
- Write miss: clean victim gets an install with `req_wdata`, dirty 1, and no memory read.
- Backpressure: `mem_req_ready` held low 5 cycles means request signals stay stable throughout, with exactly one handshake.
- Reset asserted in FILL_WAIT gives IDLE the next cycle, `mem_req_valid`=0, and a late `mem_resp_valid` is ignored.

Source files
------------

// File: rtl/l2_pkg.sv
// l2_pkg: shared definitions for the L2 sequencing controller.
// Holds the controller state encoding, address field widths, address slicing
// helpers and the LRU age width. Also imported by the L1 controller, which
// reuses l2_lru_update.
package l2_pkg;

  localparam int TAG_W  = 25;
  localparam int IDX_W  = 5;
  localparam int OFF_W  = 2;
  localparam int ADDR_W = TAG_W + IDX_W + OFF_W;
  localparam int WAYS   = 4;
  localparam int LINE_W = 32;
  localparam int AGE_W  = 2;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    EVICT,
    FILL_REQ,
    FILL_WAIT,
    INSTALL,
    RESP
  } state_t;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] addr);
    return addr[OFF_W +: IDX_W];
  endfunction

  // Line-aligned memory address: offset bits forced to zero.
  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                  input logic [IDX_W-1:0] idx);
    return {tag, idx, {OFF_W{1'b0}}};
  endfunction

endpackage

// File: rtl/l2_lru_update.sv
// l2_lru_update: combinational 4-way age-based LRU update.
// Ports:
//   old_lru  in  8  {age3,age2,age1,age0} before the access
//   way      in  2  way being accessed
//   new_lru  out 8  ages after the access
// The accessed way becomes age 0; every way younger than the accessed way's
// old age ages by one; older ways keep their age. A permutation of 0..3 stays
// a permutation.
module l2_lru_update
  import l2_pkg::*;
(
  input  logic [WAYS*AGE_W-1:0] old_lru,
  input  logic [1:0]            way,
  output logic [WAYS*AGE_W-1:0] new_lru
);

  logic [AGE_W-1:0] acc_age;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    acc_age = old_lru[way*AGE_W +: AGE_W];
    new_lru = old_lru;
    for (int w = 0; w < WAYS; w++) begin
      if (w == int'(way)) begin
        new_lru[w*AGE_W +: AGE_W] = '0;
      end else if (old_lru[w*AGE_W +: AGE_W] < acc_age) begin
        new_lru[w*AGE_W +: AGE_W] = old_lru[w*AGE_W +: AGE_W] + 1'b1;
      end
    end
  end

endmodule

// File: rtl/l2_ctrl.sv
// l2_ctrl: sequencing controller for the 4-way, 32-set, 32-bit-line L2 array.
// Takes one L1 request at a time (read miss or full-line writeback), looks up
// the tags, evicts a dirty victim, fills from memory and installs the line.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_*                    L1 request (valid/ready, write, addr, wdata)
//   resp_valid, resp_data    one-cycle response; data is 0 for writes
//   arr_index, arr_way       set/way presented to the array's read ports
//   arr_tag/valid/dirty/lru  combinational state of set arr_index
//   arr_rdata                line of arr_way at arr_index
//   arr_we, arr_w*           single-cycle line+tag+valid+dirty write
//   arr_lru_we, arr_new_lru  single-cycle LRU write
//   mem_*                    main-memory request (held until ready) / response
module l2_ctrl #(
  parameter int TAG_W  = 25,
  parameter int IDX_W  = 5,
  parameter int WAYS   = 4,
  parameter int LINE_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [31:0]           req_addr,
  input  logic [LINE_W-1:0]     req_wdata,
  output logic                  resp_valid,
  output logic [LINE_W-1:0]     resp_data,
  output logic [IDX_W-1:0]      arr_index,
  input  logic [WAYS*TAG_W-1:0] arr_tag,
  input  logic [WAYS-1:0]       arr_valid,
  input  logic [WAYS-1:0]       arr_dirty,
  input  logic [2*WAYS-1:0]     arr_lru,
  input  logic [LINE_W-1:0]     arr_rdata,
  output logic [1:0]            arr_way,
  output logic                  arr_we,
  output logic [LINE_W-1:0]     arr_wdata,
  output logic [TAG_W-1:0]      arr_wtag,
  output logic                  arr_wdirty,
  output logic                  arr_lru_we,
  output logic [2*WAYS-1:0]     arr_new_lru,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [LINE_W-1:0]     mem_wdata,
  input  logic                  mem_resp_valid,
  input  logic [LINE_W-1:0]     mem_rdata
);

  import l2_pkg::*;

  state_t              state;
  logic [TAG_W-1:0]    tag_q;
  logic [IDX_W-1:0]    idx_q;
  logic                write_q;
  logic [LINE_W-1:0]   wdata_q;
  logic [LINE_W-1:0]   line_q;        // fill data from memory
  logic [1:0]          victim_q;
  logic                victim_inv_q;

  logic                hit;
  logic [1:0]          hit_way;
  logic [1:0]          vict_way;
  logic                vict_inv;
  logic                vict_dirty;
  logic [1:0]          lru_way;
  logic [2*WAYS-1:0]   lru_old;
  logic [2*WAYS-1:0]   lru_new;

  // Whole-line transfers: the byte offset carries no information here.
  logic unused_ok;
  assign unused_ok = &{1'b0, req_addr[1:0]};

  assign arr_index = idx_q;

  // Tag match and victim choice. Loops run high-to-low so the lowest
  // qualifying way is the one left standing.
  always_comb begin
    hit      = 1'b0;
    hit_way  = '0;
    vict_inv = 1'b0;
    vict_way = '0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (arr_valid[w] && arr_tag[w*TAG_W +: TAG_W] == tag_q) begin
        hit     = 1'b1;
        hit_way = 2'(w);
      end
    end
    for (int w = WAYS-1; w >= 0; w--) begin
      if (arr_lru[w*2 +: 2] == 2'd3) vict_way = 2'(w);
    end
    for (int w = WAYS-1; w >= 0; w--) begin
      if (!arr_valid[w]) begin
        vict_inv = 1'b1;
        vict_way = 2'(w);
      end
    end
  end

  assign vict_dirty = !vict_inv && arr_dirty[vict_way];

  // Array-side signals are combinational from the state: the array read port
  // must see the hit/victim way within LOOKUP to keep hit latency at 2.
  always_comb begin
    arr_way    = '0;
    arr_we     = 1'b0;
    arr_wdata  = '0;
    arr_wtag   = '0;
    arr_wdirty = 1'b0;
    arr_lru_we = 1'b0;
    lru_way    = victim_q;
    lru_old    = arr_lru;
    case (state)
      LOOKUP: begin
        arr_way = hit ? hit_way : vict_way;
        lru_way = hit_way;
        if (hit) begin
          arr_lru_we = 1'b1;
          if (write_q) begin
            arr_we     = 1'b1;
            arr_wdata  = wdata_q;
            arr_wtag   = tag_q;
            arr_wdirty = 1'b1;
          end
        end
      end
      INSTALL: begin
        arr_way    = victim_q;
        arr_we     = 1'b1;
        arr_wdata  = write_q ? wdata_q : line_q;
        arr_wtag   = tag_q;
        arr_wdirty = write_q;
        arr_lru_we = 1'b1;
        // An invalid victim is treated as the oldest way.
        if (victim_inv_q) lru_old[victim_q*2 +: 2] = 2'd3;
      end
      default: ;
    endcase
    // Reset aborts the transaction before the array commits anything.
    if (rst) begin
      arr_we     = 1'b0;
      arr_lru_we = 1'b0;
    end
  end

  l2_lru_update u_lru (
    .old_lru (lru_old),
    .way     (lru_way),
    .new_lru (lru_new)
  );

  assign arr_new_lru = arr_lru_we ? lru_new : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the reset branch is synchronous.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      resp_data     <= '0;
      mem_req_valid <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      tag_q         <= '0;
      idx_q         <= '0;
      write_q       <= 1'b0;
      wdata_q       <= '0;
      line_q        <= '0;
      victim_q      <= '0;
      victim_inv_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            tag_q     <= addr_tag(req_addr);
            idx_q     <= addr_idx(req_addr);
            write_q   <= req_write;
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            resp_valid <= 1'b1;
            resp_data  <= write_q ? '0 : arr_rdata;
            state      <= RESP;
          end else begin
            victim_q     <= vict_way;
            victim_inv_q <= vict_inv;
            if (vict_dirty) begin
              mem_req_valid <= 1'b1;
              mem_we        <= 1'b1;
              mem_addr      <= line_addr(arr_tag[vict_way*TAG_W +: TAG_W], idx_q);
              mem_wdata     <= arr_rdata;
              state         <= EVICT;
            end else if (write_q) begin
              state <= INSTALL;
            end else begin
              mem_req_valid <= 1'b1;
              mem_we        <= 1'b0;
              mem_addr      <= line_addr(tag_q, idx_q);
              state         <= FILL_REQ;
            end
          end
        end
        EVICT: begin
          if (mem_req_ready) begin
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            if (write_q) begin
              mem_req_valid <= 1'b0;
              mem_addr      <= '0;
              state         <= INSTALL;
            end else begin
              mem_addr <= line_addr(tag_q, idx_q);
              state    <= FILL_REQ;
            end
          end
        end
        FILL_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            mem_addr      <= '0;
            state         <= FILL_WAIT;
          end
        end
        FILL_WAIT: begin
          if (mem_resp_valid) begin
            line_q <= mem_rdata;
            state  <= INSTALL;
          end
        end
        INSTALL: begin
          resp_valid <= 1'b1;
          resp_data  <= write_q ? '0 : line_q;
          state      <= RESP;
        end
        RESP: begin
          resp_valid <= 1'b0;
          resp_data  <= '0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
